// File: rtl/motor_pkg.sv
// Shared definitions for the motor command path: frame constants, parser
// state encoding and default channel geometry used by the top level and
// by motorCtrl.
package motor_pkg;

  // Frame layout: SOF, idx, d_hi, d_lo, chk (chk = idx ^ d_hi ^ d_lo)
  localparam logic [7:0]  SOF       = 8'h53;
  localparam logic [7:0]  BCAST_IDX = 8'hFF;
  localparam int unsigned FRAME_LEN = 5;

  // Default channel geometry
  localparam int unsigned DEF_NUM_MOTORS = 10;
  localparam int unsigned DEF_DELTA_W    = 16;

  // Parser FSM encoding
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    IDX  = 3'd1,
    DHI  = 3'd2,
    DLO  = 3'd3,
    CHK  = 3'd4
  } parser_state_e;

endpackage

// File: rtl/motor_cmd_frame_parser.sv
// Frame parser for motor commands: byte FSM, inter-byte gap timer and
// checksum/index validation. Write and error indications are
// combinational and valid in the cycle of the CHK byte (or the timeout).
//
// Optional feature: `MOTOR_CMD_BROADCAST_EN makes idx 0xFF a broadcast.
//
// Ports:
//   CLK_10MHZ   in   system clock
//   rst_n       in   async active-low reset
//   rx_valid    in   byte strobe
//   rx_data     in   received byte
//   wr_en_c     out  accepted frame, write shadow this cycle
//   wr_idx_c    out  channel index of the accepted frame
//   wr_bcast_c  out  accepted frame targets every channel
//   wr_delta_c  out  delta of the accepted frame, sized to DELTA_W
//   err_c       out  frame discarded (bad chk, bad idx or gap timeout)
module motor_cmd_frame_parser
  import motor_pkg::*;
#(
  parameter int unsigned NUM_MOTORS  = DEF_NUM_MOTORS,
  parameter int unsigned DELTA_W     = DEF_DELTA_W,
  parameter int unsigned GAP_TIMEOUT = 2000
) (
  input  logic               CLK_10MHZ,
  input  logic               rst_n,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               wr_en_c,
  output logic [7:0]         wr_idx_c,
  output logic               wr_bcast_c,
  output logic [DELTA_W-1:0] wr_delta_c,
  output logic               err_c
);

  localparam int unsigned GAP_W = $clog2(GAP_TIMEOUT + 1);

  parser_state_e    state, state_nxt;
  logic [7:0]       idx_q, dhi_q, dlo_q;
  logic [GAP_W-1:0] gap_cnt;
  logic             timeout_c, chk_byte_c, chk_ok_c, idx_ok_c;

  // Timeout fires on the cycle the idle count would reach GAP_TIMEOUT
  assign timeout_c  = (state != IDLE) && !rx_valid &&
                      (gap_cnt == GAP_W'(GAP_TIMEOUT - 1));
  assign chk_byte_c = (state == CHK) && rx_valid;
  assign chk_ok_c   = (rx_data == (idx_q ^ dhi_q ^ dlo_q));

`ifdef MOTOR_CMD_BROADCAST_EN
  assign wr_bcast_c = (idx_q == BCAST_IDX);
`else
  assign wr_bcast_c = 1'b0;
`endif

  assign idx_ok_c   = (idx_q < 8'(NUM_MOTORS)) || wr_bcast_c;
  assign wr_en_c    = chk_byte_c && chk_ok_c && idx_ok_c;
  assign err_c      = (chk_byte_c && !(chk_ok_c && idx_ok_c)) || timeout_c;
  assign wr_idx_c   = idx_q;
  assign wr_delta_c = DELTA_W'($signed({dhi_q, dlo_q}));

  // State register
  always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; every advance is gated by rx_valid
  always_comb begin
    state_nxt = state;
    if (timeout_c) begin
      state_nxt = IDLE;
    end else if (rx_valid) begin
      unique case (state)
        IDLE:    if (rx_data == SOF) state_nxt = IDX;
        IDX:     state_nxt = DHI;
        DHI:     state_nxt = DLO;
        DLO:     state_nxt = CHK;
        CHK:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Field capture
  always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      dhi_q <= '0;
      dlo_q <= '0;
    end else if (rx_valid) begin
      if (state == IDX) idx_q <= rx_data;
      if (state == DHI) dhi_q <= rx_data;
      if (state == DLO) dlo_q <= rx_data;
    end
  end

  // Inter-byte gap counter, only running inside a frame
  always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
    if (!rst_n)                                  gap_cnt <= '0;
    else if (rx_valid || state == IDLE || timeout_c) gap_cnt <= '0;
    else                                         gap_cnt <= gap_cnt + GAP_W'(1);
  end

endmodule

// File: rtl/motor_cmd_dispatcher.sv
// Motor command dispatcher: parses framed commands, holds one pending
// delta per channel and commits all pending deltas together on tick.
//
// Optional feature: `MOTOR_CMD_BROADCAST_EN (idx 0xFF writes all channels).
//
// Ports:
//   CLK_10MHZ  in   system clock
//   rst_n      in   async active-low reset
//   rx_valid   in   byte strobe from async_receiver
//   rx_data    in   received byte
//   tick       in   4 ms commit strobe
//   delta_out  out  committed delta, channel k at [k*DELTA_W +: DELTA_W]
//   load       out  per-channel one-cycle load strobe
//   frame_ok   out  pulse, frame accepted
//   frame_err  out  pulse, frame discarded
//   err_cnt    out  saturating discarded-frame count
//   pending    out  per-channel shadow-full flags
module motor_cmd_dispatcher
  import motor_pkg::*;
#(
  parameter int unsigned NUM_MOTORS  = DEF_NUM_MOTORS,
  parameter int unsigned DELTA_W     = DEF_DELTA_W,
  parameter int unsigned GAP_TIMEOUT = 2000
) (
  input  logic                          CLK_10MHZ,
  input  logic                          rst_n,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  input  logic                          tick,
  output logic [NUM_MOTORS*DELTA_W-1:0] delta_out,
  output logic [NUM_MOTORS-1:0]         load,
  output logic                          frame_ok,
  output logic                          frame_err,
  output logic [7:0]                    err_cnt,
  output logic [NUM_MOTORS-1:0]         pending
);

  logic               wr_en_c, wr_bcast_c, err_c;
  logic [7:0]         wr_idx_c;
  logic [DELTA_W-1:0] wr_delta_c;
  logic [DELTA_W-1:0] shadow [NUM_MOTORS];
  logic [NUM_MOTORS-1:0] hit_c, commit_c;

  motor_cmd_frame_parser #(
    .NUM_MOTORS  (NUM_MOTORS),
    .DELTA_W     (DELTA_W),
    .GAP_TIMEOUT (GAP_TIMEOUT)
  ) u_parser (
    .CLK_10MHZ  (CLK_10MHZ),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .wr_en_c    (wr_en_c),
    .wr_idx_c   (wr_idx_c),
    .wr_bcast_c (wr_bcast_c),
    .wr_delta_c (wr_delta_c),
    .err_c      (err_c)
  );

  // Per-channel write decode and commit selection
  always_comb begin
    hit_c = '0;
    for (int k = 0; k < NUM_MOTORS; k++) begin
      hit_c[k] = wr_en_c && (wr_bcast_c || (wr_idx_c == 8'(k)));
    end
    commit_c = pending & {NUM_MOTORS{tick}};
  end

  // Shadow/commit array. A commit reads the pre-write shadow, and a
  // same-cycle write leaves the channel pending for the next tick.
  always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
    if (!rst_n) begin
      delta_out <= '0;
      load      <= '0;
      pending   <= '0;
      for (int k = 0; k < NUM_MOTORS; k++) shadow[k] <= '0;
    end else begin
      load    <= commit_c;
      pending <= hit_c | (pending & ~commit_c);
      for (int k = 0; k < NUM_MOTORS; k++) begin
        if (commit_c[k]) delta_out[k*DELTA_W +: DELTA_W] <= shadow[k];
        if (hit_c[k])    shadow[k] <= wr_delta_c;
      end
    end
  end

  // Frame status pulses and saturating error count
  always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
    if (!rst_n) begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      frame_ok  <= wr_en_c;
      frame_err <= err_c;
      if (err_c && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_motor_cmd_dispatcher.sv
// Self-checking bench for motor_cmd_dispatcher with a channel-level
// reference model (shadow/pending/committed arrays, error counter).
module tb_motor_cmd_dispatcher;
  import motor_pkg::*;

  localparam int unsigned NM = 10;
  localparam int unsigned DW = 16;
  localparam int unsigned GT = 2000;

  logic                 CLK_10MHZ = 1'b0;
  logic                 rst_n     = 1'b0;
  logic                 rx_valid  = 1'b0;
  logic [7:0]           rx_data   = 8'h00;
  logic                 tick      = 1'b0;
  logic [NM*DW-1:0]     delta_out;
  logic [NM-1:0]        load;
  logic                 frame_ok, frame_err;
  logic [7:0]           err_cnt;
  logic [NM-1:0]        pending;

  motor_cmd_dispatcher #(
    .NUM_MOTORS (NM), .DELTA_W (DW), .GAP_TIMEOUT (GT)
  ) dut (
    .CLK_10MHZ (CLK_10MHZ), .rst_n (rst_n), .rx_valid (rx_valid),
    .rx_data (rx_data), .tick (tick), .delta_out (delta_out), .load (load),
    .frame_ok (frame_ok), .frame_err (frame_err), .err_cnt (err_cnt),
    .pending (pending)
  );

  always #5 CLK_10MHZ = ~CLK_10MHZ;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [DW-1:0] m_shadow [NM];
  logic [DW-1:0] m_dout   [NM];
  logic [NM-1:0] m_pend;
  int            m_errcnt;

  task automatic check(input string tag, input logic [NM*DW-1:0] obs,
                       input logic [NM*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK_10MHZ);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic model_reset();
    for (int k = 0; k < NM; k++) begin
      m_shadow[k] = '0;
      m_dout[k]   = '0;
    end
    m_pend   = '0;
    m_errcnt = 0;
  endtask

  function automatic logic [NM*DW-1:0] model_dout();
    logic [NM*DW-1:0] v;
    for (int k = 0; k < NM; k++) v[k*DW +: DW] = m_dout[k];
    return v;
  endfunction

  task automatic model_commit(output logic [NM-1:0] ld);
    ld = '0;
    for (int k = 0; k < NM; k++) begin
      if (m_pend[k]) begin
        ld[k]     = 1'b1;
        m_dout[k] = m_shadow[k];
        m_pend[k] = 1'b0;
      end
    end
  endtask

  function automatic bit bcast_enabled();
`ifdef MOTOR_CMD_BROADCAST_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_state(input string tag, input logic [NM-1:0] ld_exp);
    check({tag, ".load"},    NM*DW'(load),    NM*DW'(ld_exp));
    check({tag, ".pending"}, NM*DW'(pending), NM*DW'(m_pend));
    check({tag, ".dout"},    delta_out,       model_dout());
    check({tag, ".errcnt"},  NM*DW'(err_cnt), NM*DW'(m_errcnt));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit t);
    rx_data  = b;
    rx_valid = 1'b1;
    tick     = t;
    step();
    rx_valid = 1'b0;
    tick     = 1'b0;
  endtask

  // Full frame; optionally lands tick on the CHK byte's cycle
  task automatic send_frame(input string tag, input logic [7:0] idx,
                            input logic [7:0] dhi, input logic [7:0] dlo,
                            input logic [7:0] c, input bit tick_on_chk);
    logic [7:0]    fb [FRAME_LEN];
    logic [NM-1:0] ld;
    bit            ok;
    fb = '{SOF, idx, dhi, dlo, c};
    for (int i = 0; i < FRAME_LEN; i++) begin
      send_byte(fb[i], tick_on_chk && (i == FRAME_LEN - 1));
      if (i < FRAME_LEN - 1) idle(2);
    end
    ld = '0;
    if (tick_on_chk) model_commit(ld);
    ok = (c == (idx ^ dhi ^ dlo)) &&
         ((int'(idx) < NM) || (bcast_enabled() && idx == BCAST_IDX));
    if (ok) begin
      for (int k = 0; k < NM; k++) begin
        if (idx == BCAST_IDX || int'(idx) == k) begin
          m_shadow[k] = {dhi, dlo};
          m_pend[k]   = 1'b1;
        end
      end
    end else if (m_errcnt < 255) begin
      m_errcnt++;
    end
    check({tag, ".ok"},  NM*DW'(frame_ok),  NM*DW'(ok));
    check({tag, ".err"}, NM*DW'(frame_err), NM*DW'(!ok));
    check_state(tag, ld);
    step();
    check({tag, ".pulse"}, NM*DW'({frame_ok, frame_err, load}), '0);
  endtask

  task automatic do_tick(input string tag);
    logic [NM-1:0] ld;
    tick = 1'b1;
    step();
    tick = 1'b0;
    model_commit(ld);
    check_state(tag, ld);
    step();
    check({tag, ".load1cyc"}, NM*DW'(load), '0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".dout"}, delta_out, '0);
    check({tag, ".ctl"},
          NM*DW'({load, pending, frame_ok, frame_err, err_cnt}), '0);
  endtask

  initial begin
    int            n;
    logic [7:0]    idx, dhi, dlo, c;

    model_reset();
    idle(2);
    check_zero("reset");
    rst_n = 1'b1;
    step();

    // Frame for channel 2 then commit
    send_frame("t1", 8'h02, 8'h01, 8'hF4, 8'hF7, 1'b0);
    check("t1.pend2", NM*DW'(pending), NM*DW'(10'b0000000100));
    do_tick("t1.tick");
    check("t1.slice2", NM*DW'(delta_out[2*DW +: DW]), NM*DW'(16'h01F4));

    // Bad checksum
    send_frame("t2", 8'h03, 8'h00, 8'h10, 8'hAA, 1'b0);
    check("t2.errcnt", NM*DW'(err_cnt), NM*DW'(1));
    do_tick("t2.tick");

    // Last write wins
    send_frame("t3a", 8'h01, 8'h00, 8'h05, 8'h04, 1'b0);
    send_frame("t3b", 8'h01, 8'hFF, 8'hFB, 8'h05, 1'b0);
    do_tick("t3.tick");
    check("t3.slice1", NM*DW'(delta_out[1*DW +: DW]), NM*DW'(16'hFFFB));

    // Tick colliding with a write to a pending channel
    send_frame("t4a", 8'h04, 8'h00, 8'h07, 8'h03, 1'b0);
    send_frame("t4b", 8'h04, 8'h12, 8'h34, 8'h22, 1'b1);
    check("t4.slice4", NM*DW'(delta_out[4*DW +: DW]), NM*DW'(16'h0007));
    do_tick("t4.tick");
    check("t4.slice4new", NM*DW'(delta_out[4*DW +: DW]), NM*DW'(16'h1234));

    // Gap timeout after 53 05
    send_byte(SOF, 1'b0);
    idle(2);
    send_byte(8'h05, 1'b0);
    n = 0;
    while (!frame_err && n < int'(GT) + 10) begin
      step();
      n++;
    end
    check("t5.timeout_seen", NM*DW'(frame_err), NM*DW'(1));
    check("t5.timeout_win", NM*DW'(n >= int'(GT) - 2 && n <= int'(GT) + 2),
          NM*DW'(1));
    m_errcnt++;
    check("t5.errcnt", NM*DW'(err_cnt), NM*DW'(m_errcnt));
    idle(1);
    send_frame("t5.after", 8'h05, 8'h00, 8'h09, 8'h0C, 1'b0);
    send_frame("t5.idx12", 8'h0C, 8'h00, 8'h01, 8'h0D, 1'b0);
    do_tick("t5.tick");

    // Broadcast index (error unless the feature is enabled)
    send_frame("t6", BCAST_IDX, 8'h00, 8'h20, 8'hDF, 1'b0);
    do_tick("t6.tick");

    // Randomized frames against the model
    for (int r = 0; r < 40; r++) begin
      idx = ($urandom_range(0, 9) == 0) ? BCAST_IDX : 8'($urandom_range(0, 15));
      dhi = 8'($urandom);
      dlo = 8'($urandom);
      c   = idx ^ dhi ^ dlo;
      if ($urandom_range(0, 99) < 15) c = c ^ 8'($urandom_range(1, 255));
      send_frame("rnd", idx, dhi, dlo, c, $urandom_range(0, 99) < 20);
      if ($urandom_range(0, 99) < 30) do_tick("rnd.tick");
    end
    do_tick("rnd.final");

    // Asynchronous reset mid-frame after 53 07 00
    send_byte(SOF, 1'b0);
    idle(2);
    send_byte(8'h07, 1'b0);
    idle(2);
    send_byte(8'h00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("t7.async");
    model_reset();
    idle(2);
    rst_n = 1'b1;
    step();
    send_frame("t7.after", 8'h07, 8'h00, 8'h33, 8'h34, 1'b0);
    do_tick("t7.tick");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/motor_cmd_dispatcher.md
Name: motor_cmd_dispatcher

Overview:
- Parses framed motor commands from the UART byte stream (async_receiver output).
- Buffers one signed delta per motor channel in shadow registers.
- On each 4 ms tick, commits every pending delta to its motorCtrl instance with a one-cycle load strobe, so all motors that received a command start the same step period together.
- Sits between the UART receiver and the motorCtrl array in the top level. It replaces the ad-hoc 3-byte parser.

Parameters:
- NUM_MOTORS, 10, number of motor channels (1..16)
- DELTA_W, 16, width of signed delta per channel
- GAP_TIMEOUT, 2000, max clock cycles between bytes inside a frame before abort

Ports:
- CLK_10MHZ  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx_valid  input  1  one-cycle strobe, rx_data valid
- rx_data  input  8  received byte
- tick  input  1  one-cycle commit strobe (clock_4ms)
- delta_out  output  NUM_MOTORS*DELTA_W  per-channel committed delta; channel k occupies bits [k*DELTA_W +: DELTA_W]
- load  output  NUM_MOTORS  per-channel one-cycle strobe; delta_out slice is valid in that same cycle
- frame_ok  output  1  one-cycle pulse when a frame is accepted
- frame_err  output  1  one-cycle pulse when a frame is discarded
- err_cnt  output  8  saturating count of discarded frames
- pending  output  NUM_MOTORS  per-channel shadow-full flags

Behaviour:
- Reset, asynchronous on rst_n low, with immediate effect:
  - state=IDLE; shadow regs, delta_out, load, pending, frame_ok, frame_err, err_cnt all 0; gap counter 0.
  - A frame in progress is dropped and not counted as an error.
- Frame format, 5 bytes: 0x53 ('S'), idx, d_hi, d_lo, chk, where chk = idx ^ d_hi ^ d_lo.
  - Delta = {d_hi,d_lo}, sign-extended or truncated to DELTA_W.
- FSM states: IDLE -> IDX -> DHI -> DLO -> CHK -> IDLE. Each transition happens only on rx_valid.
  - IDLE: 0x53 moves to IDX. Any other byte is ignored; no error.
  - IDX: latch idx. DHI and DLO latch their data bytes.
  - CHK: on rx_valid, run validation; the FSM returns to IDLE in the same cycle regardless of outcome.
- Validation in CHK:
  - chk mismatch, or idx >= NUM_MOTORS: frame_err pulse, err_cnt+1 (saturates at 255), no shadow write.
  - Otherwise: shadow[idx] <= delta, pending[idx] <= 1, frame_ok pulse.
  - frame_ok and frame_err are asserted in the cycle after the CHK byte's rx_valid.
- Overwrite: a valid frame for a channel that is already pending replaces the shadow value (last wins). This is not an error.
- Gap timeout:
  - Counter resets on every rx_valid and runs only while state != IDLE.
  - Reaching GAP_TIMEOUT forces IDLE, with frame_err pulse and err_cnt+1.
- Commit on tick: for each k with pending[k]=1:
  - delta_out slice k <= shadow[k], load[k]=1 for exactly one cycle (cycle after tick), pending[k] <= 0.
  - Channels not pending keep delta_out unchanged and load[k]=0.
- tick coinciding with a frame write to channel k (same cycle):
  - Commit uses the pre-write shadow, and only if pending was already set.
  - The new value is stored and pending[k] ends at 1, to be committed on the next tick.
- tick with no pending channels: no load strobes.
- rx_valid pulses closer than 2 cycles apart are not required to be handled (UART byte spacing ≥ 434 cycles).

Optional Feature:
- Macro: MOTOR_CMD_BROADCAST_EN.
- Defined: idx = 0xFF is valid. A passing frame writes delta to all NUM_MOTORS shadows and sets all pending bits, with the same tick-collision rule per channel.
- Undefined: 0xFF is treated as out of range (frame_err, err_cnt+1).

Decomposition:
- Shared package motor_pkg holds:
  - frame constants: SOF=8'h53, BCAST_IDX=8'hFF, FRAME_LEN=5
  - FSM state encoding: IDLE, IDX, DHI, DLO, CHK (3-bit)
  - defaults for NUM_MOTORS and DELTA_W, also used by the top level and motorCtrl
- One sub-module is natural: motor_cmd_frame_parser (FSM, gap timer, checksum; outputs wr_en/wr_idx/wr_delta/err).
  - The dispatcher keeps the shadow/pending/commit array and err_cnt.

Test Plan:
- Frame 53 02 01 F4 F7 then tick: frame_ok pulse; pending[2]=1; cycle after tick load=10'b0000000100, slice 2 = 0x01F4, pending[2]=0.
- Frame 53 03 00 10 AA (bad chk): frame_err pulse, err_cnt=1, pending unchanged, no load on next tick.
- Frames for idx 1 (0x0005) then idx 1 (0xFFFB), then tick: single load[1]; slice 1 = 0xFFFB (-5).
- Frame for idx 4 whose CHK rx_valid lands in the same cycle as tick, with idx 4 previously pending value 0x0007: load[4] carries 0x0007; pending[4]=1; next tick loads the new value.
- Send 53 05 then no bytes for 2000 cycles: frame_err, err_cnt+1, FSM back in IDLE; following valid frame accepted. Idx 0x0C (≥10) → frame_err.
- rst_n low mid-frame after 53 07 00: all outputs 0, err_cnt unchanged at 0. With MOTOR_CMD_BROADCAST_EN, frame 53 FF 00 20 DF plus tick → load all ones, every slice 0x0020.
